// File: rtl/fma16_pkg.sv
// Shared constants for the fma16 datapath and its write-back queue.
package fma16_pkg;
  localparam int unsigned RESW    = 16;
  localparam int unsigned FLAGW   = 4;
  localparam int unsigned FLAG_NV = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;
  localparam logic [RESW-1:0] FMA16_QNAN = 16'h7E00;
endpackage

// File: rtl/fma16_wb_fifo.sv
// Circular-buffer FIFO holding write-back entries; caller guarantees no overflow/underflow.
module fma16_wb_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   level_q;

  // Storage is deliberately not reset; empty-queue outputs are masked upstream.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en_i, rd_en_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;
endmodule

// File: rtl/fma16_wb.sv
// Write-back stage for fma16: queues result/flags/tag, keeps sticky flags and an op counter.
module fma16_wb
  import fma16_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_result,
  input  logic [3:0]             in_flags,
  input  logic [TAGW-1:0]        in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_result,
  output logic [3:0]             out_flags,
  output logic [TAGW-1:0]        out_tag,
  input  logic                   flags_clr,
  output logic [3:0]             sticky_flags,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            op_count
);
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = RESW + FLAGW + TAGW;

  logic          accept, pop;
  logic [EW-1:0] head;
  logic [LW-1:0] level_w;
  logic [3:0]    sticky_q, sticky_d;
  logic [15:0]   op_count_q, op_count_d;

  assign in_ready  = (level_w < LW'(DEPTH));
  assign out_valid = (level_w != '0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  fma16_wb_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (accept),
    .wr_data_i ({in_result, in_flags, in_tag}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .level_o   (level_w)
  );

  // Mask the head when empty so stale storage never leaks to the consumer.
  always_comb begin
    {out_result, out_flags, out_tag} = out_valid ? head : '0;
  end

  always_comb begin
    sticky_d   = (flags_clr ? '0 : sticky_q) | (accept ? in_flags : '0);
    op_count_d = accept ? op_count_q + 16'd1 : op_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_q   <= '0;
      op_count_q <= '0;
    end else begin
      sticky_q   <= sticky_d;
      op_count_q <= op_count_d;
    end
  end

  assign sticky_flags = sticky_q;
  assign op_count     = op_count_q;
  assign level        = level_w;
endmodule

// File: tb/tb_fma16_wb.sv
// Self-checking bench for fma16_wb: queue-based reference model plus directed literal checks.
module tb_fma16_wb;
  localparam int DEPTH = 4;
  localparam int TAGW  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int EW    = 20 + TAGW;

  logic            clk;
  logic            reset;
  logic            in_valid, in_ready;
  logic [15:0]     in_result;
  logic [3:0]      in_flags;
  logic [TAGW-1:0] in_tag;
  logic            out_valid, out_ready;
  logic [15:0]     out_result;
  logic [3:0]      out_flags;
  logic [TAGW-1:0] out_tag;
  logic            flags_clr;
  logic [3:0]      sticky_flags;
  logic [LW-1:0]   level;
  logic [15:0]     op_count;

  fma16_wb #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_result    (in_result),
    .in_flags     (in_flags),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .out_tag      (out_tag),
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags),
    .level        (level),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {result, flags, tag}
  logic [EW-1:0] mq[$];
  int unsigned   m_ops = 0;
  logic [3:0]    m_sticky = '0;
  bit            chk_en = 0;
  logic [EW-1:0] exp_head;

  always @(posedge clk) begin : model
    bit acc, pp;
    if (reset) begin
      mq.delete();
      m_ops    = 0;
      m_sticky = '0;
      chk_en   = 1;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pp  = out_ready && (mq.size() > 0);
      m_sticky = (flags_clr ? 4'b0 : m_sticky) | (acc ? in_flags : 4'b0);
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({in_result, in_flags, in_tag});
        m_ops = (m_ops + 1) % 65536;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (chk_en) begin
      exp_head = (mq.size() > 0) ? mq[0] : '0;
      chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("level",     32'(level),     32'(mq.size()));
      chk("out_entry", 32'({out_result, out_flags, out_tag}), 32'(exp_head));
      chk("sticky",    32'(sticky_flags), 32'(m_sticky));
      chk("op_count",  32'(op_count),  m_ops);
    end
  end

  task automatic cyc(input bit v, input logic [15:0] r, input logic [3:0] f,
                     input logic [TAGW-1:0] t, input bit ordy, input bit clr, input bit rst);
    in_valid  = v;
    in_result = r;
    in_flags  = f;
    in_tag    = t;
    out_ready = ordy;
    flags_clr = clr;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(0, '0, '0, '0, 0, 0, 1);
  endtask

  initial begin : stim
    bit saw_zero;
    logic [TAGW-1:0] t;

    do_reset();
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_result", 32'(out_result), 0);
    chk("rst_sticky", 32'(sticky_flags), 0);
    chk("rst_ops", 32'(op_count), 0);

    // Single push becomes visible one cycle later
    cyc(1, 16'h3C00, 4'b0000, 4'd1, 0, 0, 0);
    chk("one_valid", 32'(out_valid), 1);
    chk("one_result", 32'(out_result), 32'h3C00);
    chk("one_level", 32'(level), 1);
    chk("one_ops", 32'(op_count), 1);

    // Fill, ignored fifth push, ordered drain
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      t = TAGW'(i);
      cyc(1, 16'(i * 16'h1111), 4'b0000, t, 0, 0, 0);
    end
    chk("full_ready", 32'(in_ready), 0);
    chk("full_level", 32'(level), 4);
    cyc(1, 16'hDEAD, 4'b0000, 4'd5, 0, 0, 0);
    chk("full_ops", 32'(op_count), 4);
    chk("full_level2", 32'(level), 4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_tag", 32'(out_tag), i);
      cyc(0, '0, '0, '0, 1, 0, 0);
    end
    chk("drain_empty", 32'(out_valid), 0);

    // Full queue with simultaneous push and pop: pop only
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      t = TAGW'(i);
      cyc(1, 16'h4000, 4'b0000, t, 0, 0, 0);
    end
    cyc(1, 16'hBEEF, 4'hF, 4'd7, 1, 0, 0);
    chk("fullpp_level", 32'(level), 3);
    chk("fullpp_ops", 32'(op_count), 4);
    chk("fullpp_head", 32'(out_tag), 2);
    chk("fullpp_sticky", 32'(sticky_flags), 0);

    // Sticky accumulation and clear-with-push
    do_reset();
    cyc(1, 16'h1234, 4'b0001, 4'd1, 1, 0, 0);
    cyc(1, 16'h5678, 4'b1000, 4'd2, 1, 0, 0);
    chk("sticky_or", 32'(sticky_flags), 32'b1001);
    cyc(1, 16'h9ABC, 4'b0100, 4'd3, 1, 1, 0);
    chk("sticky_clr", 32'(sticky_flags), 32'b0100);

    // Reset overrides push/pop/clear with entries in flight
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      t = TAGW'(i);
      cyc(1, 16'h7E00, 4'b1010, t, 0, 0, 0);
    end
    chk("pre_rst_level", 32'(level), 3);
    cyc(1, 16'hFFFF, 4'hF, 4'd9, 1, 1, 1);
    chk("rst3_level", 32'(level), 0);
    chk("rst3_valid", 32'(out_valid), 0);
    chk("rst3_result", 32'(out_result), 0);
    chk("rst3_sticky", 32'(sticky_flags), 0);
    chk("rst3_ops", 32'(op_count), 0);

    // Random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 99) < 60, 16'($urandom), 4'($urandom), TAGW'($urandom),
          $urandom_range(0, 99) < 50, $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
    end

    // Long steady stream at level 1, op_count wraps
    do_reset();
    cyc(1, 16'h0001, 4'b0000, 4'd0, 0, 0, 0);
    saw_zero = 0;
    for (int k = 0; k < 70000; k++) begin
      cyc(1, 16'($urandom), 4'($urandom), TAGW'($urandom), 1, $urandom_range(0, 15) == 0, 0);
      if (op_count == 16'h0000) saw_zero = 1;
    end
    chk("stream_level", 32'(level), 1);
    chk("stream_ops", 32'(op_count), 32'd4465);
    chk("stream_wrap", 32'(saw_zero), 1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fma16_wb.md
FMA16_WB -- requirements
Module: fma16_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter TAGW, default 4, width of the operation tag carried with each result.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  fma16 result and flags present this cycle.
REQ-006 in_ready  output  1  stage can accept a result this cycle.
REQ-007 in_result  input  16  half-precision result from fma16.
REQ-008 in_flags  input  4  {invalid, overflow, underflow, inexact} from fma16.
REQ-009 in_tag  input  TAGW  issuer's operation id.
REQ-010 out_valid  output  1  head entry available to consumer.
REQ-011 out_ready  input  1  consumer accepts head entry.
REQ-012 out_result  output  16  head entry result.
REQ-013 out_flags  output  4  head entry flags.
REQ-014 out_tag  output  TAGW  head entry tag.
REQ-015 flags_clr  input  1  clear sticky flag register.
REQ-016 sticky_flags  output  4  OR of flags of all results accepted since the last clear or reset.
REQ-017 level  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-018 op_count  output  16  number of accepted results, modulo 2^16.

Function
REQ-019 Accept = in_valid & in_ready; pop = out_valid & out_ready.
REQ-020 in_ready SHALL be 1 exactly when level < DEPTH; no pass-through when full, even if pop occurs the same cycle.
REQ-021 out_valid SHALL be 1 exactly when level > 0; outputs driven from registered storage only, never combinationally from in_*.
REQ-022 Latency: a result accepted in cycle N SHALL appear at out_* no earlier than cycle N+1 (N+1 when the queue was empty).
REQ-023 Order SHALL be strict FIFO; result, flags, and tag of one entry SHALL travel together.
REQ-024 out_* SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 When out_valid=0, out_result, out_flags, and out_tag SHALL be 0.
REQ-026 level: +1 on accept only, -1 on pop only, unchanged on simultaneous accept and pop (possible only when 0<level<DEPTH).
REQ-027 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-028 sticky_flags next = (flags_clr ? 0 : sticky_flags) | (accept ? in_flags : 0); flags are captured at accept time, not at pop.
REQ-029 op_count SHALL increment by 1 per accept and wrap from 16'hFFFF to 16'h0000.
REQ-030 in_valid while in_ready=0 SHALL change no state; the upstream holds its data.

Reset
REQ-031 While reset=1 at a clock edge: level=0, pointers=0, sticky_flags=0, op_count=0, out_valid=0, out_* =0, and in_ready=1 in the following cycle.
REQ-032 Reset SHALL override simultaneous accept, pop, and flags_clr; entries in flight are discarded.
REQ-033 Queue storage contents need not be reset; they SHALL be unobservable because of REQ-025.

Structure
REQ-034 Package fma16_pkg SHALL hold the flag bit indices (NV=3, OF=2, UF=1, NX=0), the FLAGW=4 constant, and the canonical NaN constant 16'h7E00 shared with fma16.
REQ-035 Queue storage and pointers SHALL be one sub-module, fma16_wb_fifo, parameterised on DEPTH and entry width 20+TAGW; sticky flags and op_count stay in fma16_wb.

Verification
REQ-036 Reset, then push {16'h3C00, 4'b0000, tag 1} -> out_valid=1 next cycle with out_result=16'h3C00, level=1, op_count=1.
REQ-037 Push 4 results with out_ready=0 -> in_ready=0 and level=4; a 5th in_valid is ignored and op_count stays 4; drain gives tags in push order.
REQ-038 Full queue: assert in_valid and out_ready together -> pop only, level=3, the pushed result is not accepted.
REQ-039 Push flags 4'b0001 then 4'b1000 -> sticky_flags=4'b1001; flags_clr with a push of 4'b0100 in the same cycle -> sticky_flags=4'b0100.
REQ-040 Continuous push/pop at level 1 for 70000 cycles -> level stays 1, op_count wraps through 0, order preserved.
REQ-041 Assert reset with level=3 and out_ready=1 -> next cycle level=0, out_valid=0, out_result=0, sticky_flags=0.
